// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_XMIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ABORT = 3'd4
  } tx_sched_state_t;

  // bit_cnt value seen on the strobe that ends the stop bit
  localparam logic [3:0] LAST_BIT_IDX = 4'd9;
  localparam int         FRAME_BITS   = 10;
  localparam int         TO_CNT_W     = 16;

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Round-robin arbiter: the search starts at ptr and wraps around.
// When prio0_en is set, requester 0 wins regardless of the pointer.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic                 prio0_en,
  output logic [N-1:0]         win,
  output logic [$clog2(N)-1:0] win_idx
);

  localparam int IW = $clog2(N);

  logic found;
  int   idx;

  // first requester at or after ptr, modulo N; optional override for index 0
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        found   = 1'b1;
        win_idx = IW'(idx);
      end
    end
    if (prio0_en && req[0]) begin
      found   = 1'b1;
      win_idx = '0;
    end
    win = '0;
    if (found) win[win_idx] = 1'b1;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: arbitrates NUM_REQ byte sources onto a single
// TX datapath and sequences its load / baud-enable / done controls.
// Optional build macro UART_TX_SCHED_PRIO_EN gives requester 0 strict
// priority; its grants then leave the round-robin pointer untouched.
//
// state | meaning
// IDLE  | waiting for any req; winner latched into owner
// LOAD  | one cycle: load byte, clear datapath done, gnt[owner]
// XMIT  | baud enabled; ends on last stop-bit strobe or timeout
// DONE  | one cycle: set datapath done, done[owner]
// ABORT | one cycle: clear datapath done, err[owner]
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 32768
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic [NUM_REQ-1:0]   err,
  output logic                 busy,
  output logic [7:0]           tx_data,
  output logic                 load,
  output logic                 transmitting,
  output logic                 set_done,
  output logic                 clr_done,
  input  logic                 shift,
  input  logic [3:0]           bit_cnt
);

  localparam int                  IW      = $clog2(NUM_REQ);
  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [IW-1:0]       IDX_MAX = IW'(NUM_REQ - 1);

  tx_sched_state_t     state, state_nxt;
  logic [IW-1:0]       owner, ptr;
  logic [TO_CNT_W-1:0] to_cnt;
  logic [NUM_REQ-1:0]  win;
  logic [IW-1:0]       win_idx;
  logic                prio0_en;

`ifdef UART_TX_SCHED_PRIO_EN
  assign prio0_en = 1'b1;
`else
  assign prio0_en = 1'b0;
`endif

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req      (req),
    .ptr      (ptr),
    .prio0_en (prio0_en),
    .win      (win),
    .win_idx  (win_idx)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // next-state logic; completion is tested first so it beats a same-cycle timeout
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (|win) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_XMIT;
      ST_XMIT: begin
        if (shift && (bit_cnt == LAST_BIT_IDX)) state_nxt = ST_DONE;
        else if (to_cnt == TO_LAST)             state_nxt = ST_ABORT;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      ST_ABORT: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // latch the arbitration winner when leaving IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         owner <= '0;
    else if (state == ST_IDLE && |win)  owner <= win_idx;
  end

  // advance the round-robin pointer past the owner during LOAD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (state == ST_LOAD && !(prio0_en && owner == '0)) begin
      ptr <= (owner == IDX_MAX) ? '0 : owner + 1'b1;
    end
  end

  // frame timeout counter: cleared in LOAD, saturating count in XMIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                to_cnt <= '0;
    else if (state == ST_LOAD)                 to_cnt <= '0;
    else if (state == ST_XMIT && to_cnt != '1) to_cnt <= to_cnt + 1'b1;
  end

  // output decode from registered state and owner
  always_comb begin
    gnt          = '0;
    done         = '0;
    err          = '0;
    tx_data      = 8'h00;
    load         = 1'b0;
    transmitting = 1'b0;
    set_done     = 1'b0;
    clr_done     = 1'b0;
    busy         = (state != ST_IDLE);
    case (state)
      ST_LOAD: begin
        load       = 1'b1;
        clr_done   = 1'b1;
        gnt[owner] = 1'b1;
        tx_data    = req_data[8*int'(owner) +: 8];
      end
      ST_XMIT:  transmitting = 1'b1;
      ST_DONE: begin
        set_done    = 1'b1;
        done[owner] = 1'b1;
      end
      ST_ABORT: begin
        clr_done   = 1'b1;
        err[owner] = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched (NUM_REQ=4, TIMEOUT_CYC=100).
module tb_uart_tx_sched;
  import uart_pkg::*;

  localparam int N  = 4;
  localparam int TO = 100;
`ifdef UART_TX_SCHED_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic [8*N-1:0] req_data;
  logic [N-1:0] gnt, done, err;
  logic         busy, load, transmitting, set_done, clr_done, shift;
  logic [7:0]   tx_data;
  logic [3:0]   bit_cnt;

  always #5 clk = ~clk;

  uart_tx_sched #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .gnt(gnt), .done(done), .err(err), .busy(busy), .tx_data(tx_data),
    .load(load), .transmitting(transmitting), .set_done(set_done),
    .clr_done(clr_done), .shift(shift), .bit_cnt(bit_cnt)
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string name);
    chk(name, {7'd0, gnt, done, err, busy, tx_data, load, transmitting, set_done, clr_done}, 32'd0);
  endtask

  // 10 modeled datapath strobes, bit_cnt 0..9, then DONE and IDLE checks
  task automatic finish_frame(input int exp_idx);
    bit_cnt = 4'd0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("xmit_transmitting", transmitting, 1);
        chk("xmit_load", load, 0);
        chk("xmit_gnt", gnt, 0);
      end
      @(negedge clk);
      shift = 1'b1; bit_cnt = 4'(k);
      @(negedge clk);
      shift = 1'b0;
      if (k < 9) chk("xmit_no_done", done, 0);
    end
    chk("done", done, 32'd1 << exp_idx);
    chk("set_done", set_done, 1);
    chk("err_on_done", err, 0);
    chk("transmitting_in_done", transmitting, 0);
    chk("busy_in_done", busy, 1);
    @(negedge clk);
    chk("busy_idle", busy, 0);
    chk("gnt_idle", gnt, 0);
    chk("done_idle", done, 0);
  endtask

  // caller is at a negedge in IDLE; grant is expected after one edge
  task automatic run_frame(input logic [3:0] r, input logic [31:0] d,
                           input int exp_idx, input bit drop);
    logic [31:0] dv;
    dv = d;
    req = r; req_data = d;
    @(negedge clk);
    chk("gnt", gnt, 32'd1 << exp_idx);
    chk("load", load, 1);
    chk("clr_done_load", clr_done, 1);
    chk("tx_data", tx_data, dv[8*exp_idx +: 8]);
    chk("busy_load", busy, 1);
    if (drop) req = '0;
    finish_frame(exp_idx);
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    int          idx;
    int          idx_prio;
  } vec_t;

  vec_t tbl[8];
  int   rr_exp[5];
  int   c;

  initial begin
    // pointer evolution (rr): 0 ->3 ->1 ->2 ->0 ->0 ->2 ->3 ->1
    tbl[0] = '{4'b0100, 32'h11A5_2233, 2, 2};
    tbl[1] = '{4'b0011, 32'h4455_6677, 0, 0};
    tbl[2] = '{4'b0011, 32'h8899_AABB, 1, 0};
    tbl[3] = '{4'b1001, 32'hC3D4_E5F6, 3, 0};
    tbl[4] = '{4'b1000, 32'h0F00_00FF, 3, 3};
    tbl[5] = '{4'b0110, 32'h1234_5678, 1, 1};
    tbl[6] = '{4'b1111, 32'h9ABC_DEF0, 2, 0};
    tbl[7] = '{4'b0001, 32'h0000_0081, 0, 0};

    rst_n = 1'b0; req = '0; req_data = '0; shift = 1'b0; bit_cnt = 4'd0;
    @(negedge clk);
    chk_zero("reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("idle_after_reset");

    // single-frame vectors, request dropped after each grant
    for (int i = 0; i < 8; i++)
      run_frame(tbl[i].req, tbl[i].data, PRIO ? tbl[i].idx_prio : tbl[i].idx, 1'b1);

    // round-robin with all requests held
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
    rr_exp = PRIO ? '{0, 0, 0, 0, 0} : '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) run_frame(4'b1111, 32'hD3C2_B1A0, rr_exp[i], 1'b0);
    req = '0;

    // two requesters held: 0,3,0 round-robin, 0,0,0 with priority
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
    run_frame(4'b1001, 32'h7E00_0042, 0, 1'b0);
    run_frame(4'b1001, 32'h7E00_0042, PRIO ? 0 : 3, 1'b0);
    run_frame(4'b1001, 32'h7E00_0042, 0, 1'b0);
    req = '0;
    @(negedge clk);

    // timeout: no strobes, err after TO cycles of XMIT
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
    req = 4'b0010; req_data = 32'h0000_5A00;
    @(negedge clk);
    chk("to_gnt", gnt, 4'b0010);
    chk("to_tx_data", tx_data, 8'h5A);
    req = '0;
    c = 0;
    for (int i = 0; i < 3 * TO; i++) begin
      @(negedge clk);
      c++;
      if (err != '0 || done != '0) break;
    end
    chk("to_cycles", c, TO + 1);
    chk("to_err", err, 4'b0010);
    chk("to_no_done", done, 0);
    chk("to_clr_done", clr_done, 1);
    chk("to_transmitting", transmitting, 0);
    @(negedge clk);
    chk("to_busy_idle", busy, 0);
    chk("to_err_idle", err, 0);

    // last strobe lands on the timeout cycle: done wins
    req = 4'b0001; req_data = 32'h0000_00C7;
    @(negedge clk);
    chk("sim_gnt", gnt, 4'b0001);
    req = '0;
    for (int i = 1; i <= TO; i++) begin
      @(negedge clk);
      if (i <= 9) begin
        shift = 1'b1; bit_cnt = 4'(i - 1);
      end else if (i == TO) begin
        chk("sim_pre_err", err, 0);
        chk("sim_pre_transmitting", transmitting, 1);
        shift = 1'b1; bit_cnt = 4'd9;
      end else begin
        shift = 1'b0;
      end
    end
    @(negedge clk);
    shift = 1'b0;
    chk("sim_done", done, 4'b0001);
    chk("sim_err", err, 0);
    @(negedge clk);
    chk("sim_busy_idle", busy, 0);
    chk("sim_err_idle", err, 0);

    // reset mid-frame at bit_cnt 5; pending request served from pointer 0
    req = 4'b0100; req_data = 32'h0033_0000;
    @(negedge clk);
    chk("rst_gnt", gnt, 4'b0100);
    req = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); shift = 1'b1; bit_cnt = 4'(k);
      @(negedge clk); shift = 1'b0;
    end
    @(negedge clk);
    bit_cnt = 4'd5;
    chk("rst_pre_transmitting", transmitting, 1);
    rst_n = 1'b0;
    #1;
    chk_zero("rst_async_outputs");
    req = 4'b1001; req_data = 32'h9900_0011;
    @(negedge clk);
    chk_zero("rst_held_outputs");
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_gnt_after", gnt, 4'b0001);
    chk("rst_tx_after", tx_data, 8'h11);
    req = '0;
    finish_frame(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
